// File: rtl/fetch_sequencer.sv
// Instruction-fetch / program-counter stage: runs the 8-phase cycle,
// drives the ROM address nibbles, captures instruction words and resolves
// all control flow with a 3-level circular return stack.
//
// Ports:
//   clock, reset            clock and async active-high reset
//   data_in[3:0]            ROM data nibble (sampled end of M1 / M2)
//   take_branch, isz_taken  JCN / ISZ conditions (sampled end of X3)
//   pair_value[7:0]         register pair for JIN (sampled end of X3)
//   addr_out[3:0]           address nibble in A1/A2/A3, else 0
//   addr_valid, sync        high in A1..A3 / high in X3
//   phase[2:0]              current phase, A1=0 .. X3=7
//   inst_opcode/operand     first word of the current instruction
//   second_word             cycle fetching the second byte
//   inst_valid              X1..X3 of a first-word cycle
module fetch_sequencer #(
    parameter int PC_WIDTH    = 12,
    parameter int STACK_DEPTH = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       take_branch,
    input  logic       isz_taken,
    input  logic [7:0] pair_value,
    output logic [3:0] addr_out,
    output logic       addr_valid,
    output logic       sync,
    output logic [2:0] phase,
    output logic [3:0] inst_opcode,
    output logic [3:0] inst_operand,
    output logic       second_word,
    output logic       inst_valid
);

    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [3:0]          operand_q, operand_d;
    logic [3:0]          hi_q, hi_d;
    logic [3:0]          lo_q, lo_d;
    logic                second_word_q, second_word_d;
    logic [3:0]          addr_out_q, addr_out_d;
    logic                addr_valid_q, addr_valid_d;
    logic                sync_q, sync_d;
    logic                inst_valid_q, inst_valid_d;

    logic [SP_W-1:0]     sp_next, sp_prev;
    logic                two_word;

    assign sp_next = (sp_q == SP_LAST) ? '0 : sp_q + SP_W'(1);
    assign sp_prev = (sp_q == '0) ? SP_LAST : sp_q - SP_W'(1);

    // FIM is the even-operand half of opcode 0x2; the odd half is SRC.
    assign two_word = (opcode_q == 4'h1) || (opcode_q == 4'h4) ||
                      (opcode_q == 4'h5) || (opcode_q == 4'h7) ||
                      (opcode_q == 4'h2 && !operand_q[0]);

    always_comb begin
        phase_d       = phase_e'(phase_q + 3'd1);
        pc_d          = pc_q;
        stack_d       = stack_q;
        sp_d          = sp_q;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        second_word_d = second_word_q;

        case (phase_q)
            PH_M1: begin
                if (second_word_q) hi_d = data_in;
                else               opcode_d = data_in;
            end
            PH_M2: begin
                if (second_word_q) lo_d = data_in;
                else               operand_d = data_in;
                pc_d = pc_q + PC_WIDTH'(1);
            end
            PH_X3: begin
                if (second_word_q) begin
                    // pc_q already points past the second byte here
                    second_word_d = 1'b0;
                    case (opcode_q)
                        4'h4: pc_d = {operand_q, hi_q, lo_q};
                        4'h5: begin
                            stack_d[sp_q] = pc_q;
                            sp_d          = sp_next;
                            pc_d          = {operand_q, hi_q, lo_q};
                        end
                        4'h1: if (take_branch) pc_d = {pc_q[11:8], hi_q, lo_q};
                        4'h7: if (isz_taken)   pc_d = {pc_q[11:8], hi_q, lo_q};
                        default: ;
                    endcase
                end else if (two_word) begin
                    second_word_d = 1'b1;
                end else if (opcode_q == 4'h3 && operand_q[0]) begin
                    pc_d = {pc_q[11:8], pair_value};
                end else if (opcode_q == 4'hC) begin
                    sp_d = sp_prev;
                    pc_d = stack_q[sp_prev];
                end
            end
            default: ;
        endcase

        // Outputs are registered from the next-state values.
        case (phase_d)
            PH_A1:   addr_out_d = pc_d[3:0];
            PH_A2:   addr_out_d = pc_d[7:4];
            PH_A3:   addr_out_d = pc_d[11:8];
            default: addr_out_d = 4'h0;
        endcase
        addr_valid_d = (phase_d <= PH_A3);
        sync_d       = (phase_d == PH_X3);
        inst_valid_d = (phase_d >= PH_X1) && !second_word_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q       <= PH_A1;
            pc_q          <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
            sp_q          <= '0;
            opcode_q      <= 4'h0;
            operand_q     <= 4'h0;
            hi_q          <= 4'h0;
            lo_q          <= 4'h0;
            second_word_q <= 1'b0;
            addr_out_q    <= 4'h0;
            addr_valid_q  <= 1'b1;
            sync_q        <= 1'b0;
            inst_valid_q  <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            pc_q          <= pc_d;
            stack_q       <= stack_d;
            sp_q          <= sp_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            second_word_q <= second_word_d;
            addr_out_q    <= addr_out_d;
            addr_valid_q  <= addr_valid_d;
            sync_q        <= sync_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    assign phase        = phase_q;
    assign addr_out     = addr_out_q;
    assign addr_valid   = addr_valid_q;
    assign sync         = sync_q;
    assign inst_opcode  = opcode_q;
    assign inst_operand = operand_q;
    assign second_word  = second_word_q;
    assign inst_valid   = inst_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural ROM answers the
// address nibbles, and every cycle is checked against hand-computed values.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       take_branch = 1'b0;
    logic       isz_taken = 1'b0;
    logic [7:0] pair_value = 8'h00;
    logic [3:0] addr_out;
    logic       addr_valid;
    logic       sync;
    logic [2:0] phase;
    logic [3:0] inst_opcode;
    logic [3:0] inst_operand;
    logic       second_word;
    logic       inst_valid;

    logic [7:0] rom [4096];
    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.PC_WIDTH(12), .STACK_DEPTH(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .take_branch  (take_branch),
        .isz_taken    (isz_taken),
        .pair_value   (pair_value),
        .addr_out     (addr_out),
        .addr_valid   (addr_valid),
        .sync         (sync),
        .phase        (phase),
        .inst_opcode  (inst_opcode),
        .inst_operand (inst_operand),
        .second_word  (second_word),
        .inst_valid   (inst_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic check_reset_vals;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_addr_out", 32'(addr_out), 32'd0);
        check("rst_addr_valid", 32'(addr_valid), 32'd1);
        check("rst_sync", 32'(sync), 32'd0);
        check("rst_opcode", 32'(inst_opcode), 32'd0);
        check("rst_operand", 32'(inst_operand), 32'd0);
        check("rst_second_word", 32'(second_word), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
    endtask

    // Leaves the bench just after a negedge in phase A1.
    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One full instruction cycle starting just after a negedge in A1.
    task automatic fetch(input logic [11:0] exp_a, input logic exp_sw);
        logic [11:0] a;
        a = 12'h000;
        for (int p = 0; p < 8; p++) begin
            check("phase", 32'(phase), 32'(p));
            check("second_word", 32'(second_word), 32'(exp_sw));
            check("inst_valid", 32'(inst_valid),
                  (p >= 5 && !exp_sw) ? 32'd1 : 32'd0);
            check("sync", 32'(sync), (p == 7) ? 32'd1 : 32'd0);
            check("addr_valid", 32'(addr_valid), (p < 3) ? 32'd1 : 32'd0);
            case (p)
                0: a[3:0]  = addr_out;
                1: a[7:4]  = addr_out;
                2: a[11:8] = addr_out;
                default: check("addr_idle", 32'(addr_out), 32'd0);
            endcase
            if (p == 3) data_in = rom[a][7:4];
            if (p == 4) data_in = rom[a][3:0];
            @(negedge clock);
        end
        check("fetch_addr", 32'(a), 32'(exp_a));
    endtask

    initial begin
        // NOP stream: PC advances by one each cycle
        clear_rom();
        do_reset();
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b0);
        fetch(12'h002, 1'b0);

        // JUN 0x4A 0x5C
        clear_rom();
        rom[12'h000] = 8'h4A;
        rom[12'h001] = 8'h5C;
        do_reset();
        fetch(12'h000, 1'b0);
        check("jun_opcode", 32'(inst_opcode), 32'h4);
        check("jun_operand", 32'(inst_operand), 32'hA);
        fetch(12'h001, 1'b1);
        check("jun_opcode_hold", 32'(inst_opcode), 32'h4);
        check("jun_operand_hold", 32'(inst_operand), 32'hA);
        fetch(12'hA5C, 1'b0);

        // JMS 0x123 from 0x010, BBL back to 0x012
        clear_rom();
        rom[12'h000] = 8'h40;
        rom[12'h001] = 8'h10;
        rom[12'h010] = 8'h51;
        rom[12'h011] = 8'h23;
        rom[12'h123] = 8'hC0;
        do_reset();
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b1);
        fetch(12'h010, 1'b0);
        fetch(12'h011, 1'b1);
        fetch(12'h123, 1'b0);
        fetch(12'h012, 1'b0);

        // JCN across a page boundary, taken then not taken
        clear_rom();
        rom[12'h000] = 8'h40;
        rom[12'h001] = 8'hFE;
        rom[12'h0FE] = 8'h14;
        rom[12'h0FF] = 8'h80;
        take_branch = 1'b1;
        do_reset();
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b1);
        fetch(12'h0FE, 1'b0);
        fetch(12'h0FF, 1'b1);
        fetch(12'h180, 1'b0);
        take_branch = 1'b0;
        do_reset();
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b1);
        fetch(12'h0FE, 1'b0);
        fetch(12'h0FF, 1'b1);
        fetch(12'h100, 1'b0);

        // Four nested JMS, four BBL: the oldest return is overwritten
        clear_rom();
        rom[12'h000] = 8'h51;
        rom[12'h001] = 8'h00;
        rom[12'h100] = 8'h52;
        rom[12'h101] = 8'h00;
        rom[12'h200] = 8'h53;
        rom[12'h201] = 8'h00;
        rom[12'h300] = 8'h50;
        rom[12'h301] = 8'h50;
        rom[12'h050] = 8'hC0;
        rom[12'h302] = 8'hC0;
        rom[12'h202] = 8'hC0;
        rom[12'h102] = 8'hC0;
        do_reset();
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b1);
        fetch(12'h100, 1'b0);
        fetch(12'h101, 1'b1);
        fetch(12'h200, 1'b0);
        fetch(12'h201, 1'b1);
        fetch(12'h300, 1'b0);
        fetch(12'h301, 1'b1);
        fetch(12'h050, 1'b0);
        fetch(12'h302, 1'b0);
        fetch(12'h202, 1'b0);
        fetch(12'h102, 1'b0);
        fetch(12'h302, 1'b0);

        // FIM whose data byte looks like JIN, then JIN, then ISZ taken
        clear_rom();
        rom[12'h000] = 8'h22;
        rom[12'h001] = 8'h33;
        rom[12'h002] = 8'h31;
        rom[12'h07B] = 8'h70;
        rom[12'h07C] = 8'h90;
        pair_value = 8'h7B;
        isz_taken = 1'b1;
        do_reset();
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b1);
        fetch(12'h002, 1'b0);
        fetch(12'h07B, 1'b0);
        fetch(12'h07C, 1'b1);
        fetch(12'h090, 1'b0);
        isz_taken = 1'b0;

        // Async reset in M2 of a JUN second word
        clear_rom();
        rom[12'h000] = 8'h4A;
        rom[12'h001] = 8'h5C;
        do_reset();
        fetch(12'h000, 1'b0);
        for (int p = 0; p < 4; p++) begin
            if (p == 3) data_in = 4'h5;
            @(negedge clock);
        end
        check("mid_phase_m2", 32'(phase), 32'd4);
        check("mid_second_word", 32'(second_word), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clock);
        reset = 1'b0;
        fetch(12'h000, 1'b0);
        fetch(12'h001, 1'b1);
        fetch(12'hA5C, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and program-counter stage directly upstream of the datapath.
- Runs the 8-phase instruction cycle: A1 A2 A3 M1 M2 X1 X2 X3.
- Drives the 12-bit ROM address as three 4-bit nibbles and captures the opcode/operand nibbles from the data bus.
- Presents inst_opcode/inst_operand to the decoder and datapath. Owns the PC and a 3-level return stack, and resolves all control flow, using the datapath's take_branch for conditional jumps.

Parameters:
- PC_WIDTH, 12, program counter width; must equal 3 nibbles.
- STACK_DEPTH, 3, return-stack entries.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  4  ROM data nibble, sampled at end of M1 and M2
- take_branch  input  1  JCN condition from datapath, sampled at end of X3
- isz_taken  input  1  ISZ condition (incremented register != 0), sampled at end of X3
- pair_value  input  8  register-pair value for JIN, sampled at end of X3
- addr_out  output  4  address nibble, valid in A1/A2/A3, 0 otherwise
- addr_valid  output  1  high in A1, A2, A3
- sync  output  1  high during X3
- phase  output  3  current phase, A1=0 … X3=7
- inst_opcode  output  4  opcode nibble of the current instruction
- inst_operand  output  4  operand nibble of the current instruction
- second_word  output  1  high for the whole instruction cycle that fetches the second byte of a two-word instruction
- inst_valid  output  1  high in X1–X3 of a first-word cycle

Behaviour:
- Reset (async, all state):
  - phase=A1, PC=0, stack entries=0, stack pointer=0.
  - inst_opcode=0, inst_operand=0, second_word=0, inst_valid=0.
  - addr_out=PC[3:0]=0, addr_valid=1, sync=0.
  - Reset mid-cycle abandons the instruction; first fetch after release is from address 0x000.
- Phase counter:
  - Free-running 0..7, wraps X3→A1 every 8 clocks.
  - No stall input.
- Address output:
  - A1 drives PC[3:0], A2 drives PC[7:4], A3 drives PC[11:8].
- Fetch:
  - First-word cycle: end of M1 latches data_in into inst_opcode; end of M2 latches data_in into inst_operand.
  - Second-word cycle: the same edges latch hi/lo into a target byte register; inst_opcode/inst_operand hold the first word unchanged.
  - PC increments by 1 at end of M2 of every cycle, modulo 4096 (0xFFF→0x000).
- Two-word instructions:
  - Opcodes 0x1 JCN, 0x4 JUN, 0x5 JMS, 0x7 ISZ, and 0x2 with operand[0]=0 (FIM).
  - Decode at end of X3 of the first cycle; second_word=1 for the following full cycle, then clears.
  - A two-word opcode fetched while second_word=1 is data, never decoded.
- Control-flow updates, all applied at end of X3 and overriding the M2 increment:
  - JUN: PC={operand, hi, lo}.
  - JMS: push incremented PC, then PC={operand, hi, lo}.
  - JCN: if take_branch, PC={PC[11:8], hi, lo}. PC[11:8] is the already-incremented value, so a second byte at xFF jumps into the next page.
  - ISZ: same as JCN, using isz_taken.
  - FIM: no PC effect.
  - JIN (opcode 0x3, operand[0]=1, single word): PC={PC[11:8], pair_value}.
  - BBL (opcode 0xC, single word): pop, PC=popped entry.
- Stack:
  - Circular, pointer mod STACK_DEPTH.
  - Push writes entry[ptr] and then advances ptr; a 4th push overwrites the oldest entry silently.
  - Pop retreats ptr and then reads; popping an empty stack wraps and returns whatever the entry holds. No error flag.
- inst_valid is 0 throughout second-word cycles.

Test Plan:
- Reset release, ROM all 0x00 (NOP) → addr nibbles 0,0,0 then 1,0,0; PC increments once per 8 clocks; sync pulses on every 8th clock.
- JUN 0x4A 0x5C at 0x000 → second_word=1 for cycle 2; cycle 3 addresses C,5,A (PC=0xA5C).
- JMS 0x51 0x23 at 0x010, then BBL at 0x123 → jump to 0x123; after BBL next fetch is 0x012.
- JCN 0x14 0x80 at 0x0FE with take_branch=1 → PC=0x180; same with take_branch=0 → PC=0x100.
- Four nested JMS from 0x000/0x100/0x200/0x300, then four BBL → returns 0x302, 0x202, 0x102, 0x302 (wrap overwrite).
- Async reset asserted mid-M2 of a JUN second word → all outputs at reset values immediately; next fetch from 0x000.
